// File: rtl/known_ch.sv
// Known-cluster-head table: stores up to DEPTH CH advertisements per heartbeat
// round and presents the best one (max Q, then fewest hops, then lowest slot).
module known_ch #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_KCH,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH
);

    localparam int CW = $clog2(DEPTH + 1);

    // en_KCH is a valid-only strobe with no ready: each advertisement is
    // either written (update or insert) or dropped in the cycle it arrives.

    logic                  slot_valid [DEPTH];
    logic [WORD_WIDTH-1:0] slot_id    [DEPTH];
    logic [WORD_WIDTH-1:0] slot_hops  [DEPTH];
    logic [WORD_WIDTH-1:0] slot_q     [DEPTH];
    logic [CW-1:0]         count;

    logic                  adv_valid;
    logic                  match_any;
    logic [DEPTH-1:0]      match_hit;
    logic                  insert_ok;
    logic [DEPTH-1:0]      wr_slot;
    logic [WORD_WIDTH-1:0] count_wide;

    assign adv_valid  = en_KCH && !HB_reset && (fCH_ID != '0);
    assign count_wide = WORD_WIDTH'(count);

    // Inserts stop at whichever is smaller: the round's limit or the table size.
    assign insert_ok = (count < CW'(DEPTH)) && (count_wide < HB_CHlimit);

    always_comb begin
        match_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_hit[i] = slot_valid[i] && (slot_id[i] == fCH_ID);
        end
    end

    assign match_any = |match_hit;

    always_comb begin
        wr_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (adv_valid) begin
                if (match_any)
                    wr_slot[i] = match_hit[i];
                else if (insert_ok)
                    wr_slot[i] = (count == CW'(i));
            end
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_valid[i] <= 1'b0;
                slot_id[i]    <= '0;
                slot_hops[i]  <= '0;
                slot_q[i]     <= '0;
            end
        end else if (HB_reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_valid[i] <= 1'b0;
                slot_id[i]    <= '0;
                slot_hops[i]  <= '0;
                slot_q[i]     <= '0;
            end
        end else begin
            if (adv_valid && !match_any && insert_ok)
                count <= count + CW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_slot[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_id[i]    <= fCH_ID;
                    slot_hops[i]  <= fCH_Hops;
                    slot_q[i]     <= fCH_QValue;
                end
            end
        end
    end

    logic                  best_valid;
    logic [WORD_WIDTH-1:0] best_id;
    logic [WORD_WIDTH-1:0] best_hops;
    logic [WORD_WIDTH-1:0] best_q;

    // Strict comparisons keep the earlier slot on a full tie.
    always_comb begin
        best_valid = 1'b0;
        best_id    = '0;
        best_hops  = '0;
        best_q     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] &&
                (!best_valid || (slot_q[i] > best_q) ||
                 ((slot_q[i] == best_q) && (slot_hops[i] < best_hops)))) begin
                best_valid = 1'b1;
                best_id    = slot_id[i];
                best_hops  = slot_hops[i];
                best_q     = slot_q[i];
            end
        end
    end

    assign chosenCH   = best_valid ? best_id   : '0;
    assign hopsfromCH = best_valid ? best_hops : '1;

endmodule

// File: tb/tb_known_ch.sv
// Directed table-driven bench for known_ch: vector records applied one per
// clock, plus hand sequences for reset behaviour and asynchronous reset.
module tb_known_ch;

    localparam int W = 16;

    logic         clk;
    logic         nrst;
    logic         en_KCH;
    logic         HB_reset;
    logic [W-1:0] HB_CHlimit;
    logic [W-1:0] fCH_ID;
    logic [W-1:0] fCH_Hops;
    logic [W-1:0] fCH_QValue;
    logic [W-1:0] chosenCH;
    logic [W-1:0] hopsfromCH;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic         hb;
        logic         en;
        logic [W-1:0] lim;
        logic [W-1:0] id;
        logic [W-1:0] hops;
        logic [W-1:0] q;
        logic [W-1:0] exp_ch;
        logic [W-1:0] exp_hops;
    } vec_t;

    vec_t vecs[$];

    known_ch #(.WORD_WIDTH(W), .DEPTH(5)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en_KCH     (en_KCH),
        .HB_reset   (HB_reset),
        .HB_CHlimit (HB_CHlimit),
        .fCH_ID     (fCH_ID),
        .fCH_Hops   (fCH_Hops),
        .fCH_QValue (fCH_QValue),
        .chosenCH   (chosenCH),
        .hopsfromCH (hopsfromCH)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic hb, input logic en, input int lim,
                                input int id, input int hops, input int q,
                                input int ech, input int eh);
        vec_t v;
        v.hb = hb; v.en = en; v.lim = W'(lim); v.id = W'(id);
        v.hops = W'(hops); v.q = W'(q); v.exp_ch = W'(ech); v.exp_hops = W'(eh);
        return v;
    endfunction

    // scoreboard: pops the expected {chosenCH, hopsfromCH} and compares
    task automatic check(input string name);
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        n_tests++;
        if (chosenCH !== e[2*W-1:W]) begin
            n_fail++;
            $display("FAIL %s chosenCH got %h expected %h", name, chosenCH, e[2*W-1:W]);
        end
        n_tests++;
        if (hopsfromCH !== e[W-1:0]) begin
            n_fail++;
            $display("FAIL %s hopsfromCH got %h expected %h", name, hopsfromCH, e[W-1:0]);
        end
    endtask

    task automatic idle_inputs();
        en_KCH     = 1'b0;
        HB_reset   = 1'b0;
        fCH_ID     = '0;
        fCH_Hops   = 16'hFFFF;
        fCH_QValue = '0;
    endtask

    // driver: drive on negedge, sample 1 time unit after the posedge
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        HB_reset   = v.hb;
        en_KCH     = v.en;
        HB_CHlimit = v.lim;
        fCH_ID     = v.id;
        fCH_Hops   = v.hops;
        fCH_QValue = v.q;
        exp_q.push_back({v.exp_ch, v.exp_hops});
        @(posedge clk);
        #1;
        check(name);
        idle_inputs();
    endtask

    initial begin
        nrst       = 1'b1;
        HB_CHlimit = 16'd3;
        idle_inputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        exp_q.push_back({16'h0000, 16'hFFFF});
        check("reset_release");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            exp_q.push_back({16'h0000, 16'hFFFF});
            check($sformatf("reset_hold%0d", k));
        end

        // limit 3: fill, update, drop when full
        vecs.push_back(mk(0, 1, 3,  5, 2, 10,   5, 2));
        vecs.push_back(mk(0, 1, 3,  7, 1, 30,   7, 1));
        vecs.push_back(mk(0, 1, 3,  9, 3, 20,   7, 1));
        vecs.push_back(mk(0, 1, 3,  7, 4,  5,   9, 3));
        vecs.push_back(mk(0, 1, 3, 11, 1, 99,   9, 3));
        // full table still accepts an update of an existing ID
        vecs.push_back(mk(0, 1, 3,  5, 6, 25,   5, 6));
        // q tie resolved by fewer hops; ID 0 is ignored
        vecs.push_back(mk(1, 0, 3,  0, 0,  0,   0, 16'hFFFF));
        vecs.push_back(mk(0, 1, 3,  2, 3, 50,   2, 3));
        vecs.push_back(mk(0, 1, 3,  4, 2, 50,   4, 2));
        vecs.push_back(mk(0, 1, 3,  0, 0, 999,  4, 2));
        // HB_reset beats a simultaneous advertisement
        vecs.push_back(mk(1, 1, 3,  6, 1, 40,   0, 16'hFFFF));
        // limit 8 capped by DEPTH=5
        vecs.push_back(mk(0, 1, 8, 21, 1, 10,  21, 1));
        vecs.push_back(mk(0, 1, 8, 22, 2, 20,  22, 2));
        vecs.push_back(mk(0, 1, 8, 23, 3, 30,  23, 3));
        vecs.push_back(mk(0, 1, 8, 24, 4, 40,  24, 4));
        vecs.push_back(mk(0, 1, 8, 25, 5, 50,  25, 5));
        vecs.push_back(mk(0, 1, 8, 26, 6, 60,  25, 5));
        vecs.push_back(mk(0, 1, 8, 21, 7, 60,  21, 7));
        // full tie on q and hops: lowest slot index wins
        vecs.push_back(mk(0, 1, 8, 23, 7, 60,  21, 7));
        // limit 0 blocks inserts
        vecs.push_back(mk(1, 0, 0,  0, 0,  0,   0, 16'hFFFF));
        vecs.push_back(mk(0, 1, 0, 40, 1, 10,   0, 16'hFFFF));
        // unsigned Q compare, then lowering limit keeps entries
        vecs.push_back(mk(0, 1, 5, 31, 1, 16'h7FFF, 31, 1));
        vecs.push_back(mk(0, 1, 5, 32, 2, 16'h8000, 32, 2));
        vecs.push_back(mk(0, 1, 1, 33, 1, 16'hFFFF, 32, 2));
        vecs.push_back(mk(0, 1, 1, 31, 9, 16'hFFFF, 31, 9));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        nrst = 1'b1;
        #1;
        exp_q.push_back({16'h0000, 16'hFFFF});
        check("async_reset");
        @(negedge clk);
        nrst = 1'b0;
        apply(mk(0, 1, 5, 50, 3, 7, 50, 3), "post_reset_insert");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/known_ch.md
Name: known_ch

Overview:
- Known-cluster-head table for an EER-RL sensor node.
- Records cluster-head (CH) advertisements (ID, hop count, Q-value) received during heartbeat rounds.
- Continuously presents the best known CH and its hop distance to the routing/transmit logic.
- Table is cleared at the start of each heartbeat round via HB_reset.

Parameters:
- WORD_WIDTH, 16, width of IDs, hop counts, Q-values and limit.
- DEPTH, 5, number of table slots (maximum storable CHs).

Ports:
- clk  input  1  system clock, rising-edge active.
- nrst  input  1  reset; asynchronous, active-high (nrst=1 resets).
- en_KCH  input  1  one-cycle strobe; fCH_* carry a valid CH advertisement.
- HB_reset  input  1  synchronous table clear for a new heartbeat round.
- HB_CHlimit  input  WORD_WIDTH  maximum number of CHs to store this round.
- fCH_ID  input  WORD_WIDTH  advertised CH node ID; 0 = invalid.
- fCH_Hops  input  WORD_WIDTH  hop count to the advertised CH.
- fCH_QValue  input  WORD_WIDTH  Q-value of the advertised CH, unsigned.
- chosenCH  output  WORD_WIDTH  ID of the selected CH; 0 when the table is empty.
- hopsfromCH  output  WORD_WIDTH  hops to the selected CH; 16'hFFFF when the table is empty.

Behaviour:
- Storage: DEPTH slots, each holding valid, id, hops, q. A count register tracks the number of valid slots. Slots fill in index order 0..DEPTH-1.
- Reset (nrst=1, asynchronous): all valid=0, id/hops/q=0, count=0. Outputs therefore read chosenCH=0, hopsfromCH=16'hFFFF.
- HB_reset=1 at a rising edge clears all slots and count, same as reset. It takes priority over a simultaneous en_KCH; that advertisement is discarded.
- en_KCH=1 at a rising edge, with HB_reset=0 and fCH_ID≠0:
  - ID match on a valid slot: overwrite that slot's hops and q. Allowed even when the table is full or count ≥ limit.
  - No match and count < min(HB_CHlimit, DEPTH): write to slot[count], set valid, count+1.
  - Otherwise: drop the advertisement; no state change.
- en_KCH with fCH_ID=0: ignored.
- Lowering HB_CHlimit below count never evicts entries; it only blocks further inserts. HB_CHlimit=0 blocks all inserts.
- Selection: combinational from registered table state.
  - Pick the valid slot with the maximum q (unsigned).
  - Tie on q: fewer hops wins. Further tie: lowest slot index wins.
  - chosenCH = slot id; hopsfromCH = slot hops.
- Latency: outputs reflect an update immediately after the clock edge that writes the table (0 extra cycles). No duplicate IDs are ever stored.
- Outputs are glitch-tolerant combinational. No handshake back-pressure: every strobe is consumed or dropped in its own cycle.

Test Plan:
- Reset hold 4 cycles with fCH_ID=0, fCH_Hops=FFFF, fCH_QValue=0, en_KCH=0, then release -> chosenCH=0000, hopsfromCH=FFFF, unchanged 2 further cycles.
- Limit=3: send (ID 5,hops 2,Q 10), (ID 7,hops 1,Q 30), (ID 9,hops 3,Q 20) -> after each edge chosenCH=5/7/7, hopsfromCH=2/1/1.
- Update existing: send (ID 7,hops 4,Q 5) -> chosenCH=9, hopsfromCH=3; count remains 3.
- Limit=3 full: send (ID 11,hops 1,Q 99) -> dropped; chosenCH stays 9. Tie check: entries (ID 2,h 3,Q 50) and (ID 4,h 2,Q 50) -> chosenCH=4, hopsfromCH=2.
- HB_reset with en_KCH in the same cycle (ID 6,Q 40) -> table empty: chosenCH=0, hopsfromCH=FFFF. Limit=8 with 6 distinct IDs -> only first 5 stored.
- Assert nrst mid-round between clock edges -> outputs go to 0/FFFF immediately without a clock edge.
